// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the unified-memory
//               arbiter (FSM state, grant decision, width defaults).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W          = 12;
  localparam int DEFAULT_DATA_W          = 32;
  localparam int DEFAULT_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } arb_grant_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational grant selection. Data accesses win unless the
//               fetch side has already lost MAX_DATA_STREAK times in a row.
// Ports       : if_req  - fetch request pending
//               dm_req  - load or store pending
//               streak  - consecutive data grants taken while fetch waited
//               grant   - selected requester (GNT_NONE when idle)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK,
  parameter int STREAK_W        = $clog2(MAX_DATA_STREAK + 1)
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STREAK_W-1:0] streak,
  output arb_grant_t          grant
);

  localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_DATA_STREAK);

  always_comb begin
    grant = GNT_NONE;
    if (dm_req && (!if_req || (streak != c_streak_max))) begin
      grant = GNT_DM;
    end else if (if_req) begin
      grant = GNT_IF;
    end
  end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arbiter
// Description : Shares a single-port, 1-cycle-read-latency memory between the
//               instruction-fetch and load/store stages. One access per two
//               cycles; read data returned in holding registers with a
//               one-cycle valid pulse. pc_enable mirrors if_valid.
// Ports       : clk, nRst                      - clock, async active-low reset
//               if_req/if_addr                 - fetch request (level-held)
//               if_rdata/if_valid              - fetched word, completion pulse
//               dm_read/dm_write/dm_addr/dm_wdata - data request (level-held)
//               dm_rdata/dm_valid              - load word, completion pulse
//               pc_enable                      - PC advance strobe
//               mem_addr/mem_wdata/mem_we/mem_re - memory control (grant cycle)
//               mem_rdata                      - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = DEFAULT_ADDR_W,
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              pc_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                  STREAK_W     = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  arb_grant_t          w_pick;
  arb_grant_t          w_grant;
  logic [STREAK_W-1:0] r_streak;
  logic                r_dm_is_load;
  logic                w_dm_req;
  logic                w_dm_load;

  assign w_dm_req  = dm_read | dm_write;
  // A simultaneous read+write is a store; the read half is dropped.
  assign w_dm_load = dm_read & ~dm_write;

  mem_arb_pick #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .STREAK_W        (STREAK_W)
  ) u_pick (
    .if_req (if_req),
    .dm_req (w_dm_req),
    .streak (r_streak),
    .grant  (w_pick)
  );

  // Next state and memory strobes. Strobes are only live in the grant cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = GNT_NONE;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant = w_pick;
        case (w_pick)
          GNT_IF: begin
            mem_addr    = if_addr;
            mem_re      = 1'b1;
            w_state_nxt = WAIT_IF;
          end
          GNT_DM: begin
            mem_addr    = dm_addr;
            mem_wdata   = dm_wdata;
            mem_we      = dm_write;
            mem_re      = w_dm_load;
            w_state_nxt = WAIT_DM;
          end
          default: w_state_nxt = IDLE;
        endcase
      end
      WAIT_IF: w_state_nxt = IDLE;
      WAIT_DM: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counts data grants that overtook a waiting fetch; any fetch grant, or a
  // data grant with no fetch waiting, restarts the count.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_streak <= '0;
    end else begin
      case (w_grant)
        GNT_IF: r_streak <= '0;
        GNT_DM: begin
          if (!if_req) begin
            r_streak <= '0;
          end else if (r_streak != c_streak_max) begin
            r_streak <= r_streak + STREAK_W'(1);
          end
        end
        default: r_streak <= r_streak;
      endcase
    end
  end

  // Remembers whether the outstanding data access needs read data captured.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_dm_is_load <= 1'b0;
    end else if (w_grant == GNT_DM) begin
      r_dm_is_load <= w_dm_load;
    end
  end

  // Capture at the WAIT exit edge; valid pulses during the following IDLE cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
    end else begin
      if_valid <= (r_state == WAIT_IF);
      dm_valid <= (r_state == WAIT_DM);
      if (r_state == WAIT_IF) begin
        if_rdata <= mem_rdata;
      end
      if ((r_state == WAIT_DM) && r_dm_is_load) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

  assign pc_enable = if_valid;

endmodule : mem_access_arbiter
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_arbiter
// Description : Self-checking bench for mem_access_arbiter: directed vector
//               table, streak-order sequence, reset-in-WAIT sequence and a
//               randomized run against a transaction-level reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

  localparam int c_aw  = 12;
  localparam int c_dw  = 32;
  localparam int c_max = 4;

  logic            clk = 1'b0;
  logic            nRst = 1'b0;
  logic            if_req = 1'b0;
  logic [c_aw-1:0] if_addr = '0;
  logic [c_dw-1:0] if_rdata;
  logic            if_valid;
  logic            dm_read = 1'b0;
  logic            dm_write = 1'b0;
  logic [c_aw-1:0] dm_addr = '0;
  logic [c_dw-1:0] dm_wdata = '0;
  logic [c_dw-1:0] dm_rdata;
  logic            dm_valid;
  logic            pc_enable;
  logic [c_aw-1:0] mem_addr;
  logic [c_dw-1:0] mem_wdata;
  logic            mem_we;
  logic            mem_re;
  logic [c_dw-1:0] mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .ADDR_W          (c_aw),
    .DATA_W          (c_dw),
    .MAX_DATA_STREAK (c_max)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .pc_enable (pc_enable),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Memory device: 1-cycle read latency, writes committed at the strobe edge.
  // --------------------------------------------------------------------------
  function automatic logic [c_dw-1:0] init_word(input int a);
    logic [c_dw-1:0] w;
    w = {16'h5EED, 4'h0, a[11:0]};
    if (a == 'h010) w = 32'hDEADBEEF;
    if (a == 'hFFF) w = 32'hA5A50FFF;
    if (a == 'h000) w = 32'h00001111;
    return w;
  endfunction

  logic [c_dw-1:0] mem_dev [0:4095];
  logic            mem_ready = 1'b0;
  int              we_count  = 0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem_dev[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_we) mem_dev[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem_dev[mem_addr];
    end
    if (mem_we) we_count <= we_count + 1;
  end

  // --------------------------------------------------------------------------
  // Comparison helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_quiet(input string name);
    check({name, "_mem_re"},    mem_re,    0);
    check({name, "_mem_we"},    mem_we,    0);
    check({name, "_mem_addr"},  mem_addr,  0);
    check({name, "_mem_wdata"}, mem_wdata, 0);
    check({name, "_if_valid"},  if_valid,  0);
    check({name, "_dm_valid"},  dm_valid,  0);
    check({name, "_pc_enable"}, pc_enable, 0);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic            is_fetch;
    logic            rd;
    logic            wr;
    logic [c_aw-1:0] addr;
    logic [c_dw-1:0] wdata;
    logic            exp_re;
    logic            exp_we;
    logic [c_dw-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v, input string tag);
    int we_before;
    int lat;
    @(posedge clk); #1;
    we_before = we_count;
    if (v.is_fetch) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      dm_read  = v.rd;
      dm_write = v.wr;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
    end
    @(negedge clk);
    check({tag, "_grant_re"},    mem_re,    v.exp_re);
    check({tag, "_grant_we"},    mem_we,    v.exp_we);
    check({tag, "_grant_addr"},  mem_addr,  v.addr);
    check({tag, "_grant_wdata"}, mem_wdata, v.is_fetch ? '0 : v.wdata);
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (v.is_fetch ? if_valid : dm_valid) begin
        lat = c;
        break;
      end
    end
    if_req   = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    check({tag, "_latency"}, lat, 2);
    if (v.is_fetch) begin
      check({tag, "_if_rdata"},  if_rdata,  v.exp_rdata);
      check({tag, "_pc_enable"}, pc_enable, 1);
      check({tag, "_dm_valid"},  dm_valid,  0);
    end else begin
      check({tag, "_dm_rdata"},  dm_rdata,  v.exp_rdata);
      check({tag, "_pc_enable"}, pc_enable, 0);
      check({tag, "_if_valid"},  if_valid,  0);
    end
    check({tag, "_we_strobes"}, we_count - we_before, v.exp_we ? 1 : 0);
    @(posedge clk); #1;
    check({tag, "_pulse_end_if"}, if_valid, 0);
    check({tag, "_pulse_end_dm"}, dm_valid, 0);
  endtask

  // --------------------------------------------------------------------------
  // Reference model state for the randomized run. It reasons about whole
  // transactions: who is waiting, how many data accesses have overtaken the
  // waiting fetch, and what memory should contain.
  // --------------------------------------------------------------------------
  logic [c_dw-1:0] ref_mem [0:4095];
  bit              m_busy;
  int              m_run;
  int              if_cd, dm_cd;
  logic [c_dw-1:0] if_exp, dm_exp, if_last, dm_last;
  bit              dm_cur_load;

  task automatic model_grant_cycle();
    bit pick_dm;
    if (!m_busy && (if_req || dm_read || dm_write)) begin
      pick_dm = (dm_read || dm_write) && (!if_req || m_run < c_max);
      if (pick_dm) begin
        check("rnd_gnt_addr",  mem_addr,  dm_addr);
        check("rnd_gnt_wdata", mem_wdata, dm_wdata);
        check("rnd_gnt_we",    mem_we,    dm_write);
        check("rnd_gnt_re",    mem_re,    dm_read & ~dm_write);
        dm_cur_load = dm_read & ~dm_write;
        if (dm_write) ref_mem[dm_addr] = dm_wdata;
        else          dm_exp = ref_mem[dm_addr];
        dm_cd = 2;
        if (if_req) begin
          if (m_run < c_max) m_run++;
        end else begin
          m_run = 0;
        end
      end else begin
        check("rnd_gnt_addr",  mem_addr,  if_addr);
        check("rnd_gnt_wdata", mem_wdata, 0);
        check("rnd_gnt_we",    mem_we,    0);
        check("rnd_gnt_re",    mem_re,    1);
        if_exp = ref_mem[if_addr];
        if_cd  = 2;
        m_run  = 0;
      end
      m_busy = 1'b1;
    end else begin
      check("rnd_idle_re",    mem_re,    0);
      check("rnd_idle_we",    mem_we,    0);
      check("rnd_idle_addr",  mem_addr,  0);
      check("rnd_idle_wdata", mem_wdata, 0);
      m_busy = 1'b0;
    end
  endtask

  function automatic logic [c_aw-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 12'hFFF;
    return c_aw'($urandom_range(0, 15));
  endfunction

  // --------------------------------------------------------------------------
  // Main test
  // --------------------------------------------------------------------------
  initial begin
    bit           exp_v;
    bit           was_if, was_dm;
    int           kind;
    int           n_gnt;
    logic [c_aw-1:0] tmp_addr;
    bit           seq_dm [10];
    bit           exp_seq [10];

    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h010, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 12'h020, 32'h12345678, 1'b0, 1'b1, 32'h00000000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 12'h020, 32'h0,        1'b1, 1'b0, 32'h12345678};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 12'h030, 32'hCAFEF00D, 1'b0, 1'b1, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 12'h030, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 12'h030, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 32'h0,        1'b1, 1'b0, 32'hA5A50FFF};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 32'h00001111};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 12'h000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hA5A50FFF};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF};

    // Reset, then five idle cycles with everything quiet.
    repeat (4) @(posedge clk);
    #1;
    expect_quiet("in_reset");
    check("in_reset_if_rdata", if_rdata, 0);
    check("in_reset_dm_rdata", dm_rdata, 0);
    @(negedge clk);
    nRst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_quiet($sformatf("idle%0d", i));
      check($sformatf("idle%0d_if_rdata", i), if_rdata, 0);
      check($sformatf("idle%0d_dm_rdata", i), dm_rdata, 0);
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held continuously: four data grants, then one fetch.
    for (int i = 0; i < 10; i++) exp_seq[i] = ((i % 5) != 4);
    @(posedge clk); #1;
    if_req  = 1'b1; if_addr = 12'h111;
    dm_read = 1'b1; dm_addr = 12'h222; dm_wdata = '0;
    n_gnt = 0;
    for (int c = 0; c < 60 && n_gnt < 10; c++) begin
      @(negedge clk);
      if (mem_re) begin
        seq_dm[n_gnt] = (mem_addr == 12'h222);
        n_gnt++;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_read = 1'b0;
    check("streak_grant_count", n_gnt, 10);
    for (int i = 0; i < n_gnt; i++)
      check($sformatf("streak_order%0d_is_dm", i), seq_dm[i], exp_seq[i]);
    repeat (4) @(posedge clk);

    // Reset while a fetch is in WAIT_IF.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 12'h040;
    @(posedge clk); #1;
    check("rstw_in_wait_no_strobe", mem_re, 0);
    nRst = 1'b0;
    #1;
    if_req = 1'b0;
    check("rstw_if_rdata", if_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_quiet($sformatf("rstw%0d", i));
    end
    @(negedge clk);
    nRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstw_after%0d_if_valid", i), if_valid, 0);
      check($sformatf("rstw_after%0d_if_rdata", i), if_rdata, 0);
    end
    tmp_addr = 12'h040;
    run_vec('{1'b1, 1'b0, 1'b0, tmp_addr, 32'h0, 1'b1, 1'b0, init_word(32'h40)}, "refetch");

    // Randomized run against the transaction-level model.
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem_dev[i];
    m_busy = 1'b0; m_run = 0; if_cd = 0; dm_cd = 0;
    if_last = init_word(32'h40); dm_last = '0; dm_cur_load = 1'b0;
    if_exp = '0; dm_exp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      was_if = if_req;
      was_dm = dm_read | dm_write;

      exp_v = 1'b0;
      if (if_cd > 0) begin if_cd--; exp_v = (if_cd == 0); end
      check("rnd_if_valid",  if_valid,  exp_v);
      check("rnd_pc_enable", pc_enable, exp_v);
      if (exp_v) begin
        if_last = if_exp;
        if ($urandom_range(0, 3) != 0) if_req = 1'b0;
      end
      check("rnd_if_rdata", if_rdata, if_last);

      exp_v = 1'b0;
      if (dm_cd > 0) begin dm_cd--; exp_v = (dm_cd == 0); end
      check("rnd_dm_valid", dm_valid, exp_v);
      if (exp_v) begin
        if (dm_cur_load) dm_last = dm_exp;
        if ($urandom_range(0, 3) != 0) begin dm_read = 1'b0; dm_write = 1'b0; end
      end
      check("rnd_dm_rdata", dm_rdata, dm_last);

      if (!was_if && $urandom_range(0, 1) == 1) begin
        if_req  = 1'b1;
        if_addr = rnd_addr();
      end
      if (!was_dm && $urandom_range(0, 1) == 1) begin
        kind     = $urandom_range(0, 3);
        dm_read  = (kind != 2);
        dm_write = (kind >= 2);
        dm_addr  = rnd_addr();
        dm_wdata = $urandom;
      end

      @(negedge clk);
      model_grant_cycle();
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_access_arbiter
`default_nettype wire
